// File: rtl/jt900h_blkxfer.sv
// rtl/jt900h_blkxfer.sv - TLCS-900H block transfer/compare sequencer (LDI/LDD/CPI/CPD and repeat forms)
//
// Ports:
//   clk, rst, cen        clock, synchronous active-high reset, clock enable
//   start, op, rep, len  command; op 0=LDI 1=LDD 2=CPI 3=CPD, rep=repeat form, len 0=byte 1=word
//   abort                pending interrupt, ends a repeat loop at the next iteration boundary
//   src_ptr, dst_ptr     current source / destination pointers from the register file
//   acc                  compare operand (A or WA)
//   bc_unity             registered BC==1 from the register file
//   mem_req, mem_we, mem_addr, mem_dout, mem_din, mem_ack   memory handshake
//   dec_bc, inc_xde, dec_xde, inc_xix, dec_xix, reg_inc, reg_dec, reg_step   register update strobes
//   busy, done, flag_v, flag_z   status

module jt900h_blkxfer (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        rep,
    input  logic        len,
    input  logic        abort,
    input  logic [31:0] src_ptr,
    input  logic [31:0] dst_ptr,
    input  logic [15:0] acc,
    input  logic        bc_unity,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_dout,
    input  logic [15:0] mem_din,
    input  logic        mem_ack,
    output logic        dec_bc,
    output logic        inc_xde,
    output logic        dec_xde,
    output logic        inc_xix,
    output logic        dec_xix,
    output logic        reg_inc,
    output logic        reg_dec,
    output logic [1:0]  reg_step,
    output logic        busy,
    output logic        done,
    output logic        flag_v,
    output logic        flag_z
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic        rep_q;
    logic        len_q;
    logic [15:0] data_q;

    logic is_cp;
    logic match;
    logic upd;

    // op[1] selects the compare forms, op[0] the decrementing forms
    assign is_cp = op_q[1];
    assign match = len_q ? (data_q == acc) : (data_q[7:0] == acc[7:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= 2'd0;
            rep_q  <= 1'b0;
            len_q  <= 1'b0;
            data_q <= 16'd0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
        end else if (cen) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        rep_q <= rep;
                        len_q <= len;
                        state <= READ;
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        data_q <= len_q ? mem_din : {8'd0, mem_din[7:0]};
                        state  <= is_cp ? UPDATE : WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ack)
                        state <= UPDATE;
                end
                UPDATE: begin
                    // bc_unity still reflects BC before this iteration's decrement
                    flag_v <= ~bc_unity;
                    if (is_cp)
                        flag_z <= match;
                    if (rep_q && !bc_unity && !abort && !(is_cp && match))
                        state <= READ;
                    else
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus outputs are decoded from the state register and gated by rst so a
    // reset drops the request in the same cycle it is asserted.
    assign mem_req  = !rst && (state == READ || state == WRITE);
    assign mem_we   = !rst && (state == WRITE);
    assign mem_addr = rst ? 32'd0 : (state == READ) ? src_ptr : (state == WRITE) ? dst_ptr : 32'd0;
    assign mem_dout = (!rst && state == WRITE) ? data_q : 16'd0;

    // Strobes last one cen cycle: UPDATE always leaves on the first enabled edge
    assign upd      = !rst && cen && (state == UPDATE);
    assign dec_bc   = upd;
    assign inc_xix  = upd && (op_q == 2'd0);
    assign inc_xde  = upd && (op_q == 2'd0);
    assign dec_xix  = upd && (op_q == 2'd1);
    assign dec_xde  = upd && (op_q == 2'd1);
    assign reg_inc  = upd && (op_q == 2'd2);
    assign reg_dec  = upd && (op_q == 2'd3);
    assign reg_step = upd ? {1'b0, len_q} : 2'd0;

    assign busy = (state != IDLE);
    assign done = !rst && cen && (state == DONE);

endmodule
